// File: rtl/store_unit.sv
// store_unit: executes sb/sh/sw stores against a word-wide memory port.
// Sub-word stores read the enclosing word, merge the new byte or halfword
// into it and write it back. Whole-word stores go straight to the write.
// Misaligned or illegal requests are rejected with a single-cycle pulse
// and never touch memory.
module store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  state_t      r_state;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [15:0] r_data;
  logic [31:0] r_wdata;

  logic        w_misaligned;
  logic [1:0]  w_byteSel;
  logic        w_halfSel;
  logic [31:0] w_merged;

  // Classify the incoming request as illegal/misaligned before accepting it.
  always_comb begin
    w_misaligned = 1'b0;
    case (st_size)
      SIZE_H:  w_misaligned = st_addr[0];
      SIZE_W:  w_misaligned = |st_addr[1:0];
      SIZE_X:  w_misaligned = 1'b1;
      default: w_misaligned = 1'b0;
    endcase
  end

  // Map the latched lane number onto a physical byte/halfword slot of the word.
  // Big-endian lane k lives at bits 31-8k, i.e. physical slot 3-k (= ~k).
  always_comb begin
    w_byteSel = BIG_ENDIAN ? ~r_addr[1:0] : r_addr[1:0];
    w_halfSel = BIG_ENDIAN ? ~r_addr[1]   : r_addr[1];
  end

  // Overlay the new byte/halfword on the returned read word; others pass through.
  always_comb begin
    w_merged = mem_rdata;
    if (r_size == SIZE_B) begin
      w_merged[{w_byteSel, 3'b000} +: 8] = r_data[7:0];
    end else if (r_size == SIZE_H) begin
      w_merged[{w_halfSel, 4'b0000} +: 16] = r_data[15:0];
    end
  end

  // Main control FSM plus the latched request and write-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_data  <= 16'd0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (st_valid) begin
            r_size <= st_size;
            r_addr <= st_addr;
            r_data <= st_data[15:0];
            if (w_misaligned) begin
              r_state <= ERR;
            end else if (st_size == SIZE_W) begin
              r_wdata <= st_data;
              r_state <= WRITE;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            r_wdata <= w_merged;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    st_ready   = (r_state == IDLE) && rst_n;
    mem_req    = (r_state == READ) || (r_state == WRITE);
    mem_we     = (r_state == WRITE);
    mem_addr   = {r_addr[31:2], 2'b00};
    mem_wdata  = r_wdata;
    done       = (r_state == RESP);
    misaligned = (r_state == ERR);
  end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: scoreboard bench for store_unit. Two instances (big- and
// little-endian) share one stimulus stream and one memory responder; every
// write or rejection they produce is checked against queued expectations.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stValid;
  logic [1:0]  stSize;
  logic [31:0] stAddr;
  logic [31:0] stData;
  logic [31:0] memRdata;
  logic        memAck;

  logic        stReadyBe, memReqBe, memWeBe, doneBe, misalignedBe;
  logic [31:0] memAddrBe, memWdataBe;
  logic        stReadyLe, memReqLe, memWeLe, doneLe, misalignedLe;
  logic [31:0] memAddrLe, memWdataLe;

  typedef struct {
    bit          isErr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } expT;

  expT beQ[$];
  expT leQ[$];

  int testsRun = 0;
  int testsFailed = 0;

  int          rdWaitCfg = 0;
  int          wrWaitCfg = 0;
  logic [31:0] rdataCfg = 32'd0;
  bit          spuriousAck = 1'b0;
  int          waitCnt = 0;

  int writesSeenBe = 0, readsSeenBe = 0, doneSeenBe = 0;
  int writesSeenLe = 0;

  bit          prevWaitBe = 1'b0;
  logic        prevWeBe;
  logic [31:0] prevAddrBe, prevWdataBe;
  expT         eBe, eLe;

  store_unit #(.BIG_ENDIAN(1'b1)) dutBe (
    .clk(clk), .rst_n(rst_n), .st_valid(stValid), .st_ready(stReadyBe),
    .st_size(stSize), .st_addr(stAddr), .st_data(stData),
    .mem_req(memReqBe), .mem_we(memWeBe), .mem_addr(memAddrBe),
    .mem_wdata(memWdataBe), .mem_rdata(memRdata), .mem_ack(memAck),
    .done(doneBe), .misaligned(misalignedBe)
  );

  store_unit #(.BIG_ENDIAN(1'b0)) dutLe (
    .clk(clk), .rst_n(rst_n), .st_valid(stValid), .st_ready(stReadyLe),
    .st_size(stSize), .st_addr(stAddr), .st_data(stData),
    .mem_req(memReqLe), .mem_we(memWeLe), .mem_addr(memAddrLe),
    .mem_wdata(memWdataLe), .mem_rdata(memRdata), .mem_ack(memAck),
    .done(doneLe), .misaligned(misalignedLe)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: which requests must be rejected.
  function automatic bit modelMisaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    if (size == 2'b01) return addr[0];
    if (size == 2'b10) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Reference: the word the store must write, built lane by lane.
  function automatic logic [31:0] modelWrite(input logic [1:0] size, input logic [31:0] addr,
                                             input logic [31:0] data, input logic [31:0] rdata,
                                             input bit bigEnd);
    logic [7:0]  lanes [4];
    logic [31:0] result;
    int          lo;
    result = 32'd0;
    if (size == 2'b10) return data;
    for (int k = 0; k < 4; k++)
      lanes[k] = bigEnd ? rdata[31-8*k -: 8] : rdata[8*k +: 8];
    if (size == 2'b00) begin
      lanes[addr[1:0]] = data[7:0];
    end else begin
      lo = addr[1] ? 2 : 0;
      if (bigEnd) begin
        lanes[lo] = data[15:8];
        lanes[lo+1] = data[7:0];
      end else begin
        lanes[lo] = data[7:0];
        lanes[lo+1] = data[15:8];
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (bigEnd) result[31-8*k -: 8] = lanes[k];
      else        result[8*k +: 8]    = lanes[k];
    end
    return result;
  endfunction

  // Memory responder: acks after the configured number of wait cycles and
  // returns junk whenever it is not acking a read.
  initial begin
    memAck = 1'b0;
    memRdata = 32'hA5A5_A5A5;
    forever begin
      @(posedge clk);
      #1;
      if (memReqBe) begin
        if (waitCnt >= (memWeBe ? wrWaitCfg : rdWaitCfg)) begin
          memAck = 1'b1;
          memRdata = rdataCfg;
          waitCnt = 0;
        end else begin
          memAck = 1'b0;
          memRdata = 32'hA5A5_A5A5;
          waitCnt++;
        end
      end else begin
        memAck = spuriousAck;
        memRdata = 32'h5A5A_5A5A;
        waitCnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted write or rejection pulse
  // and checks that a waiting request holds its outputs steady.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevWaitBe = 1'b0;
      end else begin
        if (doneBe) doneSeenBe++;
        if (prevWaitBe) begin
          checkOutput("holdReq", 32'(memReqBe), 32'd1);
          checkOutput("holdWe", 32'(memWeBe), 32'(prevWeBe));
          checkOutput("holdAddr", memAddrBe, prevAddrBe);
          checkOutput("holdWdata", memWdataBe, prevWdataBe);
        end
        if (memReqBe && memAck && !memWeBe) begin
          readsSeenBe++;
          if (beQ.size() > 0) checkOutput("readAddrBe", memAddrBe, beQ[0].addr);
        end
        if (memReqBe && memAck && memWeBe) begin
          writesSeenBe++;
          checkOutput("writeQueueBe", 32'(beQ.size()), 32'd1);
          if (beQ.size() > 0) begin
            eBe = beQ.pop_front();
            checkOutput("writeKindBe", 32'(eBe.isErr), 32'd0);
            checkOutput("writeAddrBe", memAddrBe, eBe.addr);
            checkOutput("writeDataBe", memWdataBe, eBe.wdata);
          end
        end
        if (misalignedBe) begin
          checkOutput("errQueueBe", 32'(beQ.size()), 32'd1);
          if (beQ.size() > 0) begin
            eBe = beQ.pop_front();
            checkOutput("errKindBe", 32'(eBe.isErr), 32'd1);
          end
        end
        if (memReqLe && memAck && memWeLe) begin
          writesSeenLe++;
          checkOutput("writeQueueLe", 32'(leQ.size()), 32'd1);
          if (leQ.size() > 0) begin
            eLe = leQ.pop_front();
            checkOutput("writeKindLe", 32'(eLe.isErr), 32'd0);
            checkOutput("writeAddrLe", memAddrLe, eLe.addr);
            checkOutput("writeDataLe", memWdataLe, eLe.wdata);
          end
        end
        if (misalignedLe) begin
          checkOutput("errQueueLe", 32'(leQ.size()), 32'd1);
          if (leQ.size() > 0) begin
            eLe = leQ.pop_front();
            checkOutput("errKindLe", 32'(eLe.isErr), 32'd1);
          end
        end
        prevWaitBe  = memReqBe && !memAck;
        prevWeBe    = memWeBe;
        prevAddrBe  = memAddrBe;
        prevWdataBe = memWdataBe;
      end
    end
  end

  // Issue one store, queue its expected outcome and check its timing.
  task automatic applyStimulus(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] rdata,
                               input int rdWait, input int wrWait,
                               input logic [31:0] expBe, input logic [31:0] expLe);
    bit err;
    int lat, cyc, n, reqCycles, doneBefore, readsBefore, writesBefore;
    err = modelMisaligned(size, addr);
    if (err) lat = 1;
    else if (size == 2'b10) lat = 2 + wrWait;
    else lat = 3 + rdWait + wrWait;
    beQ.push_back('{isErr: err, addr: {addr[31:2], 2'b00}, wdata: expBe});
    leQ.push_back('{isErr: err, addr: {addr[31:2], 2'b00}, wdata: expLe});
    rdataCfg = rdata;
    rdWaitCfg = rdWait;
    wrWaitCfg = wrWait;
    n = 0;
    while (!stReadyBe && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) checkOutput("readyTimeout", 32'(stReadyBe), 32'd1);
    stValid = 1'b1;
    stSize = size;
    stAddr = addr;
    stData = data;
    doneBefore = doneSeenBe;
    readsBefore = readsSeenBe;
    writesBefore = writesSeenBe;
    reqCycles = 0;
    @(posedge clk);
    #1;
    stValid = 1'b0;
    stSize = 2'($urandom_range(0, 3));
    stAddr = $urandom;
    stData = $urandom;
    cyc = 0;
    while (cyc <= 60) begin
      @(negedge clk);
      cyc++;
      if (memReqBe) reqCycles++;
      checkOutput("readyLowBusy", 32'(stReadyBe), 32'd0);
      if (doneBe || misalignedBe) break;
    end
    checkOutput("latency", 32'(cyc), 32'(lat));
    checkOutput("pulseKind", 32'({doneBe, misalignedBe}), err ? 32'd1 : 32'd2);
    checkOutput("pulseLe", 32'({doneLe, misalignedLe}), err ? 32'd1 : 32'd2);
    @(negedge clk);
    checkOutput("readyAgain", 32'(stReadyBe), 32'd1);
    checkOutput("doneCount", 32'(doneSeenBe - doneBefore), err ? 32'd0 : 32'd1);
    checkOutput("readCount", 32'(readsSeenBe - readsBefore),
                (err || size == 2'b10) ? 32'd0 : 32'd1);
    checkOutput("writeCount", 32'(writesSeenBe - writesBefore), err ? 32'd0 : 32'd1);
    if (err) checkOutput("noReqOnErr", 32'(reqCycles), 32'd0);
  endtask

  // Pull reset during a stalled read and confirm the access is dropped.
  task automatic resetDuringRead();
    int doneBefore, writesBefore;
    doneBefore = doneSeenBe;
    writesBefore = writesSeenBe;
    rdWaitCfg = 10;
    wrWaitCfg = 0;
    rdataCfg = 32'h0BAD_F00D;
    stValid = 1'b1;
    stSize = 2'b00;
    stAddr = 32'h0000_0300;
    stData = 32'h0000_0077;
    @(posedge clk);
    #1;
    stValid = 1'b0;
    @(negedge clk);
    checkOutput("rstReadReq", 32'(memReqBe), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstReqDropped", 32'(memReqBe), 32'd0);
    checkOutput("rstReady", 32'(stReadyBe), 32'd1);
    repeat (15) @(negedge clk);
    checkOutput("rstNoWrite", 32'(writesSeenBe - writesBefore), 32'd0);
    checkOutput("rstNoDone", 32'(doneSeenBe - doneBefore), 32'd0);
    checkOutput("rstIdleReq", 32'(memReqBe), 32'd0);
  endtask

  // Main sequence: reset checks, directed vectors, waits, reset abort, random.
  initial begin
    logic [1:0]  rSize;
    logic [31:0] rAddr, rData, rRdata;
    rst_n = 1'b0;
    stValid = 1'b0;
    stSize = 2'b00;
    stAddr = 32'd0;
    stData = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReadyLow", 32'(stReadyBe), 32'd0);
    checkOutput("rstMemReq", 32'(memReqBe), 32'd0);
    checkOutput("rstMemWe", 32'(memWeBe), 32'd0);
    checkOutput("rstMemAddr", memAddrBe, 32'd0);
    checkOutput("rstMemWdata", memWdataBe, 32'd0);
    checkOutput("rstDone", 32'(doneBe), 32'd0);
    checkOutput("rstMisaligned", 32'(misalignedBe), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstReadyHigh", 32'(stReadyBe), 32'd1);

    applyStimulus(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1357_9BDF, 0, 0,
                  32'hDEAD_BEEF, 32'hDEAD_BEEF);
    applyStimulus(2'b00, 32'h0000_0101, 32'h0000_00AA, 32'h1122_3344, 0, 0,
                  32'h11AA_3344, 32'h1122_AA44);
    applyStimulus(2'b01, 32'h0000_0202, 32'h1234_5678, 32'hCAFE_BABE, 0, 0,
                  32'hCAFE_5678, 32'h5678_BABE);
    applyStimulus(2'b01, 32'h0000_0200, 32'h1234_5678, 32'hCAFE_BABE, 0, 0,
                  32'h5678_BABE, 32'hCAFE_5678);
    applyStimulus(2'b00, 32'h0000_0103, 32'h0000_00AA, 32'h1122_3344, 0, 0,
                  32'h1122_33AA, 32'hAA22_3344);
    applyStimulus(2'b01, 32'h0000_0203, 32'h1234_5678, 32'hCAFE_BABE, 0, 0, 32'd0, 32'd0);
    applyStimulus(2'b11, 32'h0000_0100, 32'hDEAD_BEEF, 32'hCAFE_BABE, 0, 0, 32'd0, 32'd0);
    applyStimulus(2'b10, 32'h0000_0102, 32'hDEAD_BEEF, 32'hCAFE_BABE, 0, 0, 32'd0, 32'd0);
    applyStimulus(2'b00, 32'h0000_0402, 32'h0000_0055, 32'h0102_0304, 3, 3,
                  32'h0102_5504, 32'h0155_0304);
    applyStimulus(2'b10, 32'h0000_0500, 32'h8765_4321, 32'h0, 0, 3,
                  32'h8765_4321, 32'h8765_4321);

    spuriousAck = 1'b1;
    applyStimulus(2'b10, 32'h0000_0040, 32'hFACE_0001, 32'h0, 0, 0,
                  32'hFACE_0001, 32'hFACE_0001);
    applyStimulus(2'b11, 32'h0000_0044, 32'hFACE_0002, 32'h0, 0, 0, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("spuriousNoReq", 32'(memReqBe), 32'd0);
    spuriousAck = 1'b0;

    resetDuringRead();

    for (int i = 0; i < 12; i++) begin
      rSize = 2'($urandom_range(0, 3));
      rAddr = $urandom;
      rData = $urandom;
      rRdata = $urandom;
      applyStimulus(rSize, rAddr, rData, rRdata, $urandom_range(0, 2), $urandom_range(0, 2),
                    modelWrite(rSize, rAddr, rData, rRdata, 1'b1),
                    modelWrite(rSize, rAddr, rData, rRdata, 1'b0));
    end

    repeat (2) @(negedge clk);
    checkOutput("beQueueEmpty", 32'(beQ.size()), 32'd0);
    checkOutput("leQueueEmpty", 32'(leQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
